uart_cmd_decoder: RTL and testbench

- Consumes the byte stream from the serial receiver (data byte, one-cycle ready strobe, end-of-packet strobe) and parses framed command packets.
- Payload is buffered. It is replayed as register writes only after the checksum verifies.
- Sits between the UART RX stage and the test-harness register file in the unicone PSX test design.

---
 rtl/uart_cmd_decoder_if.sv | 29 ++
 rtl/uart_cmd_decoder.sv | 172 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// ============================================================================
// Module : uart_cmd_decoder_if
// Brief  : Register-write bus between the command decoder and the register file
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cmd_decoder_if;
    logic       wr_en;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module : uart_cmd_decoder
// Brief  : Parses SYNC/ADDR/LEN/payload/CHK frames from the UART RX stream and
//          replays verified payloads as register writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         LEN_W     = 5
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic [7:0]   rx_data,
    input  wire logic         rx_data_ready,
    input  wire logic         rx_endofpacket,
    uart_cmd_decoder_if.master wr,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic              rx_overrun,
    output logic              busy
);

    localparam int AW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_LEN  = 3'd2,
        S_GET_DATA = 3'd3,
        S_GET_CHK  = 3'd4,
        S_REPLAY   = 3'd5
    } state_t;

    state_t           state;
    logic [7:0]       base;
    logic [7:0]       acc;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [7:0]       mem [MAX_LEN];

    logic [LEN_W-1:0] idx_next;
    logic             last_idx;
    logic             len_bad;
    logic [7:0]       chk_sum;
    logic             receiving;
    logic             truncate;

    assign idx_next  = idx + LEN_W'(1);
    assign last_idx  = (idx == len - LEN_W'(1));
    assign len_bad   = (rx_data == 8'h00) || ({1'b0, rx_data} > 9'(MAX_LEN));
    assign chk_sum   = acc + rx_data;
    assign receiving = (state == S_GET_ADDR) || (state == S_GET_LEN) ||
                       (state == S_GET_DATA) || (state == S_GET_CHK);
    assign truncate  = receiving && rx_endofpacket;
    assign busy      = (state != S_IDLE);

    // Payload buffer carries no reset; it is only read after a full frame lands.
    always_ff @(posedge clk) begin
        if ((state == S_GET_DATA) && rx_data_ready) begin
            mem[idx[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            base       <= 8'h00;
            acc        <= 8'h00;
            len        <= '0;
            idx        <= '0;
            wr.wr_en   <= 1'b0;
            wr.wr_addr <= 8'h00;
            wr.wr_data <= 8'h00;
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            rx_overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
                        state <= S_GET_ADDR;
                    end
                end

                S_GET_ADDR: begin
                    if (rx_data_ready) begin
                        base  <= rx_data;
                        acc   <= rx_data;
                        state <= S_GET_LEN;
                    end
                end

                S_GET_LEN: begin
                    if (rx_data_ready) begin
                        if (len_bad) begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            len   <= rx_data[LEN_W-1:0];
                            acc   <= chk_sum;
                            idx   <= '0;
                            state <= S_GET_DATA;
                        end
                    end
                end

                S_GET_DATA: begin
                    if (rx_data_ready) begin
                        acc <= chk_sum;
                        idx <= idx_next;
                        if (last_idx) begin
                            state <= S_GET_CHK;
                        end
                    end
                end

                S_GET_CHK: begin
                    if (rx_data_ready) begin
                        if (chk_sum == 8'h00) begin
                            // Present the first write straight away so it appears
                            // on the cycle right after the CHK strobe.
                            idx        <= '0;
                            wr.wr_en   <= 1'b1;
                            wr.wr_addr <= base;
                            wr.wr_data <= mem[AW'(0)];
                            state      <= S_REPLAY;
                        end else begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end

                S_REPLAY: begin
                    rx_overrun <= rx_data_ready;
                    if (wr.wr_en && wr.wr_ready) begin
                        if (last_idx) begin
                            wr.wr_en <= 1'b0;
                            pkt_ok   <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            idx        <= idx_next;
                            wr.wr_addr <= base + 8'(idx_next);
                            wr.wr_data <= mem[idx_next[AW-1:0]];
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Line-idle abort wins over whatever the same-cycle byte decided.
            if (truncate) begin
                wr.wr_en <= 1'b0;
                pkt_err  <= 1'b1;
                state    <= S_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// ============================================================================
// Module : tb_uart_cmd_decoder
// Brief  : Directed self-checking bench for uart_cmd_decoder
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_ready = 1'b0;
    logic       rx_endofpacket = 1'b0;
    logic       pkt_ok;
    logic       pkt_err;
    logic       rx_overrun;
    logic       busy;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (16),
        .LEN_W     (5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_endofpacket (rx_endofpacket),
        .wr             (bus),
        .pkt_ok         (pkt_ok),
        .pkt_err        (pkt_err),
        .rx_overrun     (rx_overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, combo_cnt = 0;
    int          ok0, err0, ovr0;
    logic [15:0] wq [$];

    // Scoreboard: record accepted writes and count status pulses.
    always @(negedge clk) begin
        if (pkt_ok)     ok_cnt++;
        if (pkt_err)    err_cnt++;
        if (rx_overrun) ovr_cnt++;
        if ((pkt_ok && pkt_err) || (pkt_err && rx_overrun)) combo_cnt++;
        if (bus.wr_en && bus.wr_ready) wq.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return 16'hxxxx;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_test;
        wq.delete();
        ok0  = ok_cnt;
        err0 = err_cnt;
        ovr0 = ovr_cnt;
    endtask

    task automatic send_basic(input logic [7:0] chk);
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(chk);
    endtask

    logic [15:0] wexp [3] = '{16'hFF01, 16'h0002, 16'h0103};
    int          k;

    initial begin
        bus.wr_ready = 1'b1;

        // Reset values
        #2;
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_addr_data", {16'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        check("rst_pulses_busy", {28'd0, pkt_ok, pkt_err, rx_overrun, busy}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Basic valid packet
        begin_test;
        send_basic(8'hBB);
        check("first_write_timing", {15'd0, bus.wr_en, bus.wr_addr, bus.wr_data}, {15'd0, 1'b1, 16'h1011});
        idle(4);
        check("basic_nwrites", wq.size(), 2);
        check("basic_w0", wq_at(0), 16'h1011);
        check("basic_w1", wq_at(1), 16'h1122);
        check("basic_ok", ok_cnt - ok0, 1);
        check("basic_err", err_cnt - err0, 0);
        check("basic_busy", {31'd0, busy}, 32'd0);

        // Bad checksum, then a good packet
        begin_test;
        send_basic(8'hBC);
        idle(4);
        check("badchk_nwrites", wq.size(), 0);
        check("badchk_err", err_cnt - err0, 1);
        check("badchk_ok", ok_cnt - ok0, 0);
        begin_test;
        send_basic(8'hBB);
        idle(4);
        check("after_bad_nwrites", wq.size(), 2);
        check("after_bad_w1", wq_at(1), 16'h1122);
        check("after_bad_ok", ok_cnt - ok0, 1);

        // Address wrap with stalled handshakes
        begin_test;
        bus.wr_ready = 1'b0;
        send(8'hA5); send(8'hFF); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'hF8);
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            bus.wr_ready = (c % 3 == 0);
            @(negedge clk);
            check("wrap_wr_en", {31'd0, bus.wr_en}, 32'd1);
            check("wrap_addr_data", {16'd0, bus.wr_addr, bus.wr_data}, {16'd0, wexp[k]});
            @(posedge clk); #1;
            if (bus.wr_ready) k++;
        end
        bus.wr_ready = 1'b0;
        check("wrap_done", k, 3);
        idle(2);
        check("wrap_nwrites", wq.size(), 3);
        check("wrap_w1", wq_at(1), 16'h0002);
        check("wrap_ok", ok_cnt - ok0, 1);
        check("wrap_err", err_cnt - err0, 0);
        bus.wr_ready = 1'b1;

        // Length boundaries and leading garbage
        begin_test;
        send(8'hA5); send(8'h20); send(8'h00);
        idle(2);
        check("len0_err", err_cnt - err0, 1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        begin_test;
        send(8'hA5); send(8'h20); send(8'h11);
        idle(2);
        check("len17_err", err_cnt - err0, 1);
        begin_test;
        send(8'h00); send(8'h5A);
        send_basic(8'hBB);
        idle(4);
        check("garbage_err", err_cnt - err0, 0);
        check("garbage_ok", ok_cnt - ok0, 1);
        check("garbage_w0", wq_at(0), 16'h1011);

        // Truncation by end-of-packet
        begin_test;
        send(8'hA5); send(8'h10); send(8'h03); send(8'h01);
        rx_endofpacket = 1'b1;
        @(posedge clk); #1;
        rx_endofpacket = 1'b0;
        idle(2);
        check("trunc_err", err_cnt - err0, 1);
        check("trunc_busy", {31'd0, busy}, 32'd0);
        check("trunc_nwrites", wq.size(), 0);

        // Overrun during a stalled replay
        begin_test;
        bus.wr_ready = 1'b0;
        send(8'hA5); send(8'h50); send(8'h01); send(8'h77); send(8'h38);
        send(8'h99);
        check("ovr_pulse", {31'd0, rx_overrun}, 32'd1);
        check("ovr_hold", {15'd0, bus.wr_en, bus.wr_addr, bus.wr_data}, {15'd0, 1'b1, 16'h5077});
        bus.wr_ready = 1'b1;
        idle(3);
        check("ovr_count", ovr_cnt - ovr0, 1);
        check("ovr_w0", wq_at(0), 16'h5077);
        check("ovr_ok", ok_cnt - ok0, 1);

        // Reset mid-payload, then a full 16-byte packet
        begin_test;
        send(8'hA5); send(8'h30); send(8'h04); send(8'h01);
        reset_n = 1'b0;
        #1;
        check("midrst_busy_wr", {30'd0, busy, bus.wr_en}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        send(8'hA5); send(8'h40); send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(3 * i + 1));
        send(8'h38);
        idle(20);
        check("full_nwrites", wq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check("full_write", wq_at(i), {8'(8'h40 + i), 8'(3 * i + 1)});
        end
        check("full_ok", ok_cnt - ok0, 1);
        check("full_err", err_cnt - err0, 0);

        check("no_coincident_pulses", combo_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
